// File: rtl/present_pkg.sv
// Shared PRESENT definitions: S-box tables, bit-permutation layers, FSM encoding and round count.
package present_pkg;

   localparam int         ROUNDS   = 31;
   localparam logic [4:0] LAST_RND = 5'(ROUNDS);

   // Nibble i of each table holds S(i) / Sinv(i).
   localparam logic [63:0] SBOX     = 64'h2174_8FE3_DA09_B65C;
   localparam logic [63:0] SBOX_INV = 64'hA970_364B_D21C_8FE5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      KEYEXP = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } state_e;

   // Bit i moves to position 16*i mod 63; bit 63 stays put.
   function automatic logic [63:0] player(input logic [63:0] x);
      logic [63:0] y;
      int          j;
      y = '0;
      for (int i = 0; i < 63; i++) begin
         j = (16 * i) % 63;
         y[j[5:0]] = x[i];
      end
      y[63] = x[63];
      return y;
   endfunction

   function automatic logic [63:0] player_inv(input logic [63:0] x);
      logic [63:0] y;
      int          j;
      y = '0;
      for (int i = 0; i < 63; i++) begin
         j = (16 * i) % 63;
         y[i] = x[j[5:0]];
      end
      y[63] = x[63];
      return y;
   endfunction

endpackage

// File: rtl/present_sbox4.sv
// 4-bit PRESENT S-box lookup; INV selects the inverse table.
module present_sbox4
   import present_pkg::*;
#(
   parameter bit INV = 1'b0
) (
   input  logic [3:0] x_i,
   output logic [3:0] y_o
);

   localparam logic [63:0] TABLE = INV ? SBOX_INV : SBOX;

   assign y_o = TABLE[{x_i, 2'b00} +: 4];

endmodule

// File: rtl/present_cipher_core.sv
// PRESENT-80/128 encrypt/decrypt engine, one round per clock, valid/ready on both sides.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; valid,
// once raised, holds (with its data) until that edge.
module present_cipher_core
   import present_pkg::*;
#(
   parameter int KEY_W  = 80,
   parameter bit DEC_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_decrypt,
   input  logic [63:0]      in_data,
   input  logic [KEY_W-1:0] in_key,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_data,
   output logic             busy,
   output state_e           dbg_state
);

   state_e             state_q, state_d;
   logic [63:0]        dreg_q, dreg_d;
   logic [KEY_W-1:0]   kreg_q, kreg_d;
   logic [4:0]         rnd_q, rnd_d;
   logic               dec_q, dec_d;
   logic               out_valid_q, out_valid_d;
   logic [63:0]        out_data_q, out_data_d;

   logic [63:0]        rk, x, s_out, enc_nxt, dec_nxt;
   logic [KEY_W-1:0]   ksch, kisch;

   // The round key is always the top 64 bits of the key register.
   assign rk = kreg_q[KEY_W-1 -: 64];
   assign x  = dreg_q ^ rk;

   for (genvar i = 0; i < 16; i++) begin : g_sbox
      present_sbox4 #(.INV(1'b0)) u_sbox (.x_i(x[4*i +: 4]), .y_o(s_out[4*i +: 4]));
   end
   assign enc_nxt = player(s_out);

   if (DEC_EN) begin : g_dec_data
      logic [63:0] p_inv;
      assign p_inv = player_inv(x);
      for (genvar i = 0; i < 16; i++) begin : g_sbox_inv
         present_sbox4 #(.INV(1'b1)) u_sbox_inv (.x_i(p_inv[4*i +: 4]), .y_o(dec_nxt[4*i +: 4]));
      end
   end else begin : g_no_dec_data
      assign dec_nxt = '0;
   end

   if (KEY_W == 80) begin : g_key80
      logic [79:0] kr;
      logic [3:0]  ks;
      assign kr   = {kreg_q[18:0], kreg_q[79:19]};
      present_sbox4 #(.INV(1'b0)) u_ks (.x_i(kr[79:76]), .y_o(ks));
      assign ksch = {ks, kr[75:20], kr[19:15] ^ rnd_q, kr[14:0]};
      if (DEC_EN) begin : g_inv
         logic [79:0] t;
         logic [3:0]  ki;
         assign t     = {kreg_q[79:20], kreg_q[19:15] ^ rnd_q, kreg_q[14:0]};
         present_sbox4 #(.INV(1'b1)) u_ki (.x_i(t[79:76]), .y_o(ki));
         assign kisch = {t[60:0], ki, t[75:61]};
      end else begin : g_no_inv
         assign kisch = kreg_q;
      end
   end else if (KEY_W == 128) begin : g_key128
      logic [127:0] kr;
      logic [7:0]   ks;
      assign kr = {kreg_q[66:0], kreg_q[127:67]};
      present_sbox4 #(.INV(1'b0)) u_ks_hi (.x_i(kr[127:124]), .y_o(ks[7:4]));
      present_sbox4 #(.INV(1'b0)) u_ks_lo (.x_i(kr[123:120]), .y_o(ks[3:0]));
      assign ksch = {ks, kr[119:67], kr[66:62] ^ rnd_q, kr[61:0]};
      if (DEC_EN) begin : g_inv
         logic [127:0] t;
         logic [7:0]   ki;
         assign t = {kreg_q[127:67], kreg_q[66:62] ^ rnd_q, kreg_q[61:0]};
         present_sbox4 #(.INV(1'b1)) u_ki_hi (.x_i(t[127:124]), .y_o(ki[7:4]));
         present_sbox4 #(.INV(1'b1)) u_ki_lo (.x_i(t[123:120]), .y_o(ki[3:0]));
         assign kisch = {t[60:0], ki, t[119:61]};
      end else begin : g_no_inv
         assign kisch = kreg_q;
      end
   end else begin : g_bad_key_w
      $error("present_cipher_core: KEY_W must be 80 or 128");
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         dreg_q      <= '0;
         kreg_q      <= '0;
         rnd_q       <= '0;
         dec_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         dreg_q      <= dreg_d;
         kreg_q      <= kreg_d;
         rnd_q       <= rnd_d;
         dec_q       <= dec_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      dreg_d      = dreg_q;
      kreg_d      = kreg_q;
      rnd_d       = rnd_q;
      dec_d       = dec_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               dreg_d  = in_data;
               kreg_d  = in_key;
               dec_d   = in_decrypt & DEC_EN;
               rnd_d   = 5'd1;
               state_d = (in_decrypt && DEC_EN) ? KEYEXP : RUN;
            end
         end
         KEYEXP: begin
            // Walk the key forward to K32; rnd is left at 31 for the first decrypt round.
            kreg_d = ksch;
            if (rnd_q == LAST_RND) state_d = RUN;
            else                   rnd_d   = rnd_q + 5'd1;
         end
         RUN: begin
            if (dec_q) begin
               dreg_d = dec_nxt;
               kreg_d = kisch;
               rnd_d  = rnd_q - 5'd1;
               if (rnd_q == 5'd1) state_d = DONE;
            end else begin
               dreg_d = enc_nxt;
               kreg_d = ksch;
               if (rnd_q == LAST_RND) state_d = DONE;
               else                   rnd_d   = rnd_q + 5'd1;
            end
         end
         DONE: begin
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_data_d  = dreg_q ^ rk;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               out_data_d  = '0;
               rnd_d       = '0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_present_cipher_core.sv
// Directed-vector bench for present_cipher_core: 80-bit, 128-bit and encrypt-only builds.
module tb_present_cipher_core;
   import present_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         in_valid, in_decrypt, out_ready;
   logic [63:0]  in_data;
   logic [127:0] in_key;
   int           sel;      // 0: KEY_W=80, 1: KEY_W=128, 2: KEY_W=80 encrypt-only
   int           checks = 0;
   int           errors = 0;

   logic         v0, v1, v2, r0, r1, r2;
   logic         ir0, ir1, ir2, ov0, ov1, ov2, b0, b1, b2;
   logic [63:0]  od0, od1, od2;
   state_e       st0, st1, st2;

   logic         o_in_ready, o_valid, o_busy;
   logic [63:0]  o_data;
   state_e       o_state;

   assign v0 = in_valid  && (sel == 0);
   assign v1 = in_valid  && (sel == 1);
   assign v2 = in_valid  && (sel == 2);
   assign r0 = out_ready && (sel == 0);
   assign r1 = out_ready && (sel == 1);
   assign r2 = out_ready && (sel == 2);

   present_cipher_core #(.KEY_W(80), .DEC_EN(1'b1)) dut80 (
      .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(ir0), .in_decrypt(in_decrypt),
      .in_data(in_data), .in_key(in_key[79:0]), .out_valid(ov0), .out_ready(r0),
      .out_data(od0), .busy(b0), .dbg_state(st0));

   present_cipher_core #(.KEY_W(128), .DEC_EN(1'b1)) dut128 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(ir1), .in_decrypt(in_decrypt),
      .in_data(in_data), .in_key(in_key), .out_valid(ov1), .out_ready(r1),
      .out_data(od1), .busy(b1), .dbg_state(st1));

   present_cipher_core #(.KEY_W(80), .DEC_EN(1'b0)) dut_enc (
      .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(ir2), .in_decrypt(in_decrypt),
      .in_data(in_data), .in_key(in_key[79:0]), .out_valid(ov2), .out_ready(r2),
      .out_data(od2), .busy(b2), .dbg_state(st2));

   always_comb begin
      o_in_ready = ir0; o_valid = ov0; o_busy = b0; o_data = od0; o_state = st0;
      case (sel)
         1: begin o_in_ready = ir1; o_valid = ov1; o_busy = b1; o_data = od1; o_state = st1; end
         2: begin o_in_ready = ir2; o_valid = ov2; o_busy = b2; o_data = od2; o_state = st2; end
         default: ;
      endcase
   end

   localparam logic [63:0]  CT80_ZERO = 64'h5579C1387B228445;
   localparam logic [63:0]  CT80_ONES = 64'h3333DCD3213210D2;
   localparam logic [63:0]  CT80_K0F  = 64'hA112FFC72F68417B;
   localparam logic [63:0]  CT128_Z   = 64'h96DB702A2E6900AF;
   localparam logic [63:0]  ONES64    = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [127:0] ONES128   = {128{1'b1}};

   // ---------------- driver tasks ----------------
   task automatic start_op(input logic dec, input logic [63:0] data, input logic [127:0] key);
      in_decrypt = dec; in_data = data; in_key = key; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = ~data; in_key = ~key; in_decrypt = ~dec;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (o_valid !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic finish_op();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic run_op(input logic dec, input logic [63:0] data, input logic [127:0] key,
                         output logic [63:0] res, output int lat);
      start_op(dec, data, key);
      wait_out(lat);
      res = o_data;
      finish_op();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      sel = 0;
      checks++;
      if (o_in_ready !== 1'b1 || o_valid !== 1'b0 || o_data !== 64'h0 || o_busy !== 1'b0 || o_state !== IDLE) begin
         errors++;
         $display("FAIL reset80 got rdy=%b vld=%b data=%h busy=%b st=%0d exp 1 0 0 0 0",
                  o_in_ready, o_valid, o_data, o_busy, o_state);
      end
      sel = 1;
      checks++;
      if (o_in_ready !== 1'b1 || o_valid !== 1'b0 || o_data !== 64'h0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset128 got rdy=%b vld=%b data=%h busy=%b exp 1 0 0 0",
                  o_in_ready, o_valid, o_data, o_busy);
      end
      sel = 0;
   endtask

   task automatic test_enc80();
      logic [63:0] res;
      int          lat;
      sel = 0;
      start_op(1'b0, 64'h0, 128'h0);
      checks++;
      if (o_busy !== 1'b1 || o_in_ready !== 1'b0) begin
         errors++;
         $display("FAIL t1_busy got busy=%b rdy=%b exp 1 0", o_busy, o_in_ready);
      end
      wait_out(lat);
      res = o_data;
      finish_op();
      checks++;
      if (lat != 32) begin errors++; $display("FAIL t1_latency got %0d exp 32", lat); end
      checks++;
      if (res !== CT80_ZERO) begin errors++; $display("FAIL t1_data got %h exp %h", res, CT80_ZERO); end
      checks++;
      if (o_valid !== 1'b0 || o_data !== 64'h0 || o_in_ready !== 1'b1 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL t1_after_ack got vld=%b data=%h rdy=%b busy=%b exp 0 0 1 0",
                  o_valid, o_data, o_in_ready, o_busy);
      end
      run_op(1'b0, ONES64, ONES128, res, lat);
      checks++;
      if (res !== CT80_ONES || lat != 32) begin
         errors++; $display("FAIL t2_enc got %h lat %0d exp %h lat 32", res, lat, CT80_ONES);
      end
      run_op(1'b1, CT80_ONES, ONES128, res, lat);
      checks++;
      if (res !== ONES64 || lat != 63) begin
         errors++; $display("FAIL t2_dec got %h lat %0d exp %h lat 63", res, lat, ONES64);
      end
   endtask

   task automatic test_key128();
      logic [63:0]  res, pt, ct;
      logic [127:0] key;
      int           lat1, lat2;
      sel = 1;
      run_op(1'b0, 64'h0, 128'h0, res, lat1);
      checks++;
      if (res !== CT128_Z || lat1 != 32) begin
         errors++; $display("FAIL t3_enc got %h lat %0d exp %h lat 32", res, lat1, CT128_Z);
      end
      run_op(1'b1, CT128_Z, 128'h0, res, lat2);
      checks++;
      if (res !== 64'h0 || lat2 != 63) begin
         errors++; $display("FAIL t3_dec got %h lat %0d exp 0 lat 63", res, lat2);
      end
      for (int n = 0; n < 200; n++) begin
         key = {$urandom(), $urandom(), $urandom(), $urandom()};
         pt  = {$urandom(), $urandom()};
         run_op(1'b0, pt, key, ct, lat1);
         run_op(1'b1, ct, key, res, lat2);
         checks++;
         if (res !== pt || lat1 != 32 || lat2 != 63) begin
            errors++;
            $display("FAIL t3_roundtrip[%0d] got %h (lat %0d/%0d) exp %h (lat 32/63)", n, res, lat1, lat2, pt);
         end
      end
      sel = 0;
   endtask

   task automatic test_enc_only();
      logic [63:0] res;
      int          lat;
      logic        saw_keyexp;
      sel = 2;
      saw_keyexp = 1'b0;
      start_op(1'b1, 64'h0, 128'h0);
      lat = 0;
      while (o_valid !== 1'b1 && lat < 200) begin
         if (o_state == KEYEXP) saw_keyexp = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      res = o_data;
      finish_op();
      checks++;
      if (res !== CT80_ZERO || lat != 32 || saw_keyexp) begin
         errors++;
         $display("FAIL dec_disabled got %h lat %0d keyexp %b exp %h lat 32 keyexp 0", res, lat, saw_keyexp, CT80_ZERO);
      end
      sel = 0;
   endtask

   task automatic test_hold();
      int lat;
      sel = 0;
      start_op(1'b0, 64'h0, 128'h0);
      repeat (5) begin @(posedge clk); #1; end
      in_valid = 1'b1; in_data = ONES64; in_key = ONES128; in_decrypt = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (o_busy !== 1'b1 || o_in_ready !== 1'b0 || o_state !== RUN) begin
         errors++;
         $display("FAIL t4_run_pulse got busy=%b rdy=%b st=%0d exp 1 0 %0d", o_busy, o_in_ready, o_state, RUN);
      end
      in_valid = 1'b0;
      wait_out(lat);
      checks++;
      if (lat + 6 != 32 || o_data !== CT80_ZERO) begin
         errors++; $display("FAIL t4_result got %h lat %0d exp %h lat 32", o_data, lat + 6, CT80_ZERO);
      end
      in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         checks++;
         if (o_valid !== 1'b1 || o_data !== CT80_ZERO || o_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL t4_hold[%0d] got vld=%b data=%h rdy=%b exp 1 %h 0", c, o_valid, o_data, o_in_ready, CT80_ZERO);
         end
      end
      in_valid = 1'b0;
      finish_op();
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checks++;
         if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL t4_dropped[%0d] got vld=%b busy=%b rdy=%b exp 0 0 1", c, o_valid, o_busy, o_in_ready);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      sel = 0;
      out_ready = 1'b1;
      in_decrypt = 1'b0; in_key = 128'h0; in_data = 64'h0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_data = ONES64;
      wait_out(lat);
      checks++;
      if (lat != 32 || o_data !== CT80_ZERO) begin
         errors++; $display("FAIL t5_first got %h lat %0d exp %h lat 32", o_data, lat, CT80_ZERO);
      end
      @(posedge clk); #1;
      checks++;
      if (o_valid !== 1'b0 || o_in_ready !== 1'b1 || o_busy !== 1'b0) begin
         errors++; $display("FAIL t5_ack got vld=%b rdy=%b busy=%b exp 0 1 0", o_valid, o_in_ready, o_busy);
      end
      @(posedge clk); #1;
      checks++;
      if (o_busy !== 1'b1 || o_state !== RUN) begin
         errors++; $display("FAIL t5_reaccept got busy=%b st=%0d exp 1 %0d", o_busy, o_state, RUN);
      end
      wait_out(lat);
      checks++;
      if (lat != 32 || o_data !== CT80_K0F) begin
         errors++; $display("FAIL t5_second got %h lat %0d exp %h lat 32", o_data, lat, CT80_K0F);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_in_ready !== 1'b1) begin
         errors++; $display("FAIL t5_idle got vld=%b busy=%b rdy=%b exp 0 0 1", o_valid, o_busy, o_in_ready);
      end
   endtask

   task automatic test_mid_reset();
      logic [63:0] res;
      int          lat;
      sel = 0;
      start_op(1'b0, 64'h0, 128'h0);
      repeat (9) begin @(posedge clk); #1; end
      checks++;
      if (o_state !== RUN) begin errors++; $display("FAIL t6_run_state got %0d exp %0d", o_state, RUN); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (o_state !== IDLE || o_in_ready !== 1'b1 || o_valid !== 1'b0 || o_data !== 64'h0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL t6_run_abort got st=%0d rdy=%b vld=%b data=%h busy=%b exp 0 1 0 0 0",
                  o_state, o_in_ready, o_valid, o_data, o_busy);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_op(1'b0, ONES64, 128'h0, res, lat);
      checks++;
      if (res !== CT80_K0F || lat != 32) begin
         errors++; $display("FAIL t6_after_run got %h lat %0d exp %h lat 32", res, lat, CT80_K0F);
      end
      start_op(1'b1, CT80_ONES, ONES128);
      repeat (5) begin @(posedge clk); #1; end
      checks++;
      if (o_state !== KEYEXP) begin errors++; $display("FAIL t6_keyexp_state got %0d exp %0d", o_state, KEYEXP); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (o_state !== IDLE || o_in_ready !== 1'b1 || o_valid !== 1'b0 || o_data !== 64'h0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL t6_keyexp_abort got st=%0d rdy=%b vld=%b data=%h busy=%b exp 0 1 0 0 0",
                  o_state, o_in_ready, o_valid, o_data, o_busy);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_op(1'b1, CT80_ONES, ONES128, res, lat);
      checks++;
      if (res !== ONES64 || lat != 63) begin
         errors++; $display("FAIL t6_after_keyexp got %h lat %0d exp %h lat 63", res, lat, ONES64);
      end
   endtask

   // ---------------- clock/reset and sequence ----------------
   initial begin
      sel = 0;
      rst_n = 1'b0; in_valid = 1'b0; in_decrypt = 1'b0; out_ready = 1'b0;
      in_data = '0; in_key = '0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_enc80();
      test_key128();
      test_enc_only();
      test_hold();
      test_back_to_back();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
